// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: VGA scan-out prefetch has priority over a pixel writer on one single-port RAM.
// Optional VGA_FB_UNDERFLOW_CNT_EN adds a saturating 16-bit UnderflowCount output.
module vga_fb_arbiter #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 525,
  parameter int PIX_PER_WORD = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_W       = 17
) (
  input  logic              Clock25,
  input  logic              Reset_n,
  input  logic [9:0]        HorizontalCounter,
  input  logic [9:0]        VerticalCounter,
  input  logic              HSyncIn,
  input  logic              VSyncIn,
  input  logic              Wr_Req,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [31:0]       Wr_Data,
  output logic              Wr_Ack,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_WE,
  output logic [31:0]       Mem_WData,
  input  logic [31:0]       Mem_RData,
  output logic [7:0]        Pixel,
  output logic              HSyncOut,
  output logic              VSyncOut,
  output logic              UnderflowFlag
`ifdef VGA_FB_UNDERFLOW_CNT_EN
  , output logic [15:0]     UnderflowCount
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE / PIX_PER_WORD - 1);

  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic              pending, armed, fetch_active;
  logic [ADDR_W-1:0] fetch_addr;
  logic [1:0]        phase;
  logic              active, frame_start, need_read, fifo_empty;
  logic              pix_en, pop, push, underflow_now;
  logic [31:0]       head;

  assign active      = (HorizontalCounter < H_ACT) && (VerticalCounter < V_ACT);
  assign frame_start = (HorizontalCounter == '0) && (VerticalCounter == V_LAST);
  // count + pending never exceeds FIFO_DEPTH, so CW bits cannot overflow here
  assign need_read   = fetch_active && ((count + CW'(pending)) < CW'(FIFO_DEPTH));

  assign Wr_Ack    = Reset_n && Wr_Req && !need_read;
  assign Mem_WE    = Wr_Ack;
  assign Mem_WData = Wr_Data;
  assign Mem_Addr  = need_read ? fetch_addr : Wr_Addr;

  assign fifo_empty    = (count == '0);
  assign pix_en        = active && armed;
  assign pop           = pix_en && !fifo_empty && (phase == 2'd3);
  assign underflow_now = pix_en && fifo_empty;
  assign push          = pending;
  assign head          = fifo_mem[rd_ptr];

  always_ff @(posedge Clock25) begin
    if (Reset_n && push && !frame_start) fifo_mem[wr_ptr] <= Mem_RData;
  end

  always_ff @(posedge Clock25) begin
    if (!Reset_n) begin
      Pixel         <= 8'h00;
      HSyncOut      <= 1'b1;
      VSyncOut      <= 1'b1;
      UnderflowFlag <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      pending       <= 1'b0;
      fetch_addr    <= '0;
      phase         <= 2'd0;
      armed         <= 1'b0;
      fetch_active  <= 1'b0;
    end else begin
      HSyncOut <= HSyncIn;
      VSyncOut <= VSyncIn;
      Pixel    <= (pix_en && !fifo_empty) ? head[{phase, 3'b000} +: 8] : 8'h00;
      if (underflow_now) UnderflowFlag <= 1'b1;
      // frame start drops both the word landing now and any read issued this cycle
      if (frame_start) begin
        rd_ptr       <= '0;
        wr_ptr       <= '0;
        count        <= '0;
        pending      <= 1'b0;
        fetch_addr   <= '0;
        phase        <= 2'd0;
        armed        <= 1'b1;
        fetch_active <= 1'b1;
      end else begin
        pending <= need_read;
        if (need_read) begin
          fetch_addr <= fetch_addr + ADDR_W'(1);
          if (fetch_addr == LAST_ADDR) fetch_active <= 1'b0;
        end
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (pix_en) phase <= phase + 2'd1;
      end
    end
  end

`ifdef VGA_FB_UNDERFLOW_CNT_EN
  always_ff @(posedge Clock25) begin
    if (!Reset_n)
      UnderflowCount <= 16'h0000;
    else if (underflow_now && (UnderflowCount != 16'hFFFF))
      UnderflowCount <= UnderflowCount + 16'd1;
  end
`endif

endmodule
